// File: rtl/cv32e40x_rf_writeback_buffer.sv
// Register-file writeback buffer: arbitrates two writeback producers into an
// in-order FIFO, drains one entry per cycle to the RF write port and forwards
// the newest buffered value for each read port.
module cv32e40x_rf_writeback_buffer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned ADDR_WIDTH     = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 src0_valid_i,
  output logic                                 src0_ready_o,
  input  logic [ADDR_WIDTH-1:0]                src0_addr_i,
  input  logic [WORD_WIDTH-1:0]                src0_data_i,
  input  logic                                 src1_valid_i,
  output logic                                 src1_ready_o,
  input  logic [ADDR_WIDTH-1:0]                src1_addr_i,
  input  logic [WORD_WIDTH-1:0]                src1_data_i,
  input  logic                                 stall_i,
  output logic                                 we_o,
  output logic [ADDR_WIDTH-1:0]                waddr_o,
  output logic [WORD_WIDTH-1:0]                wdata_o,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_READ_PORTS-1:0]            fwd_hit_o,
  output logic [NUM_READ_PORTS*WORD_WIDTH-1:0] fwd_data_o,
  output logic                                 empty_o,
  output logic                                 full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
  logic [WORD_WIDTH-1:0] entry_data [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  enq_valid;
  logic [ADDR_WIDTH-1:0] enq_addr;
  logic [WORD_WIDTH-1:0] enq_data;

  logic [PTR_W-1:0]      age_idx [DEPTH];
  logic                  age_vld [DEPTH];

  // Occupancy flags
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty_o = empty;
  assign full_o  = full;

  // LSU has priority; ready deliberately ignores same-cycle drain
  assign src1_ready_o = !full;
  assign src0_ready_o = !full && !src1_valid_i;

  // Winning request; writes to x0 handshake but are never stored
  assign enq_valid = src1_valid_i || src0_valid_i;
  assign enq_addr  = src1_valid_i ? src1_addr_i : src0_addr_i;
  assign enq_data  = src1_valid_i ? src1_data_i : src0_data_i;
  assign push      = !full && enq_valid && (enq_addr != '0);

  // Head entry drives the RF write port unless stalled
  assign pop     = !empty && !stall_i;
  assign we_o    = pop;
  assign waddr_o = empty ? '0 : entry_addr[rd_ptr];
  assign wdata_o = empty ? '0 : entry_data[rd_ptr];

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_addr[i] <= '0;
        entry_data[i] <= '0;
      end
    end else if (push) begin
      entry_addr[wr_ptr] <= enq_addr;
      entry_data[wr_ptr] <= enq_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entries in age order, oldest first, with validity
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      age_idx[i] = rd_ptr + PTR_W'(i);
      age_vld[i] = CNT_W'(i) < count;
    end
  end

  // Forwarding: later (younger) matches override earlier ones
  always_comb begin
    fwd_hit_o  = '0;
    fwd_data_o = '0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (age_vld[i] && (raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
            (entry_addr[age_idx[i]] == raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
          fwd_hit_o[p]                           = 1'b1;
          fwd_data_o[p*WORD_WIDTH +: WORD_WIDTH] = entry_data[age_idx[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_rf_writeback_buffer.sv
// Bench for the RF writeback buffer: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_cv32e40x_rf_writeback_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WW    = 32;
  localparam int unsigned NRP   = 2;
  localparam int unsigned AW    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              src0_valid, src0_ready;
  logic [AW-1:0]     src0_addr;
  logic [WW-1:0]     src0_data;
  logic              src1_valid, src1_ready;
  logic [AW-1:0]     src1_addr;
  logic [WW-1:0]     src1_data;
  logic              stall;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [WW-1:0]     wdata;
  logic [NRP*AW-1:0] raddr;
  logic [NRP-1:0]    fwd_hit;
  logic [NRP*WW-1:0] fwd_data;
  logic              empty, full;

  always #5 clk = ~clk;

  cv32e40x_rf_writeback_buffer #(
    .DEPTH(DEPTH), .WORD_WIDTH(WW), .NUM_READ_PORTS(NRP), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src0_valid_i(src0_valid), .src0_ready_o(src0_ready),
    .src0_addr_i(src0_addr), .src0_data_i(src0_data),
    .src1_valid_i(src1_valid), .src1_ready_o(src1_ready),
    .src1_addr_i(src1_addr), .src1_data_i(src1_data),
    .stall_i(stall), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
    .raddr_i(raddr), .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
    .empty_o(empty), .full_o(full)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the buffer
  task automatic check_all(input string tag);
    logic          full_e, empty_e;
    logic [NRP-1:0] hit_e;
    logic [NRP*WW-1:0] fd_e;
    logic [AW-1:0] ra;
    empty_e = (q.size() == 0);
    full_e  = (q.size() == int'(DEPTH));
    chk({tag, ".empty"},  64'(empty),      64'(empty_e));
    chk({tag, ".full"},   64'(full),       64'(full_e));
    chk({tag, ".rdy1"},   64'(src1_ready), 64'(!full_e));
    chk({tag, ".rdy0"},   64'(src0_ready), 64'(!full_e && !src1_valid));
    chk({tag, ".we"},     64'(we),         64'(!empty_e && !stall));
    chk({tag, ".waddr"},  64'(waddr),      empty_e ? 64'(0) : 64'(q[0].a));
    chk({tag, ".wdata"},  64'(wdata),      empty_e ? 64'(0) : 64'(q[0].d));
    hit_e = '0;
    fd_e  = '0;
    for (int p = 0; p < int'(NRP); p++) begin
      ra = raddr[p*AW +: AW];
      if (ra != '0) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].a == ra) begin
            hit_e[p]        = 1'b1;
            fd_e[p*WW +: WW] = q[i].d;
            break;
          end
        end
      end
    end
    chk({tag, ".fhit"},  64'(fwd_hit),  64'(hit_e));
    chk({tag, ".fdata"}, 64'(fwd_data), 64'(fd_e));
    chk({tag, ".we_x0"}, 64'(we && (waddr == '0)), 64'(0));
  endtask

  // Apply this cycle's inputs to the model, then advance past the posedge
  task automatic tick();
    bit   is_full, push;
    ent_t e, dropped;
    is_full = (q.size() == int'(DEPTH));
    push    = 1'b0;
    e       = '0;
    if (rst_n) begin
      if (!is_full && src1_valid) begin
        e    = '{a: src1_addr, d: src1_data};
        push = (src1_addr != '0);
      end else if (!is_full && src0_valid) begin
        e    = '{a: src0_addr, d: src0_data};
        push = (src0_addr != '0);
      end
      if (q.size() > 0 && !stall) dropped = q.pop_front();
      if (push) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    src0_valid = 1'b0; src0_addr = '0; src0_data = '0;
    src1_valid = 1'b0; src1_addr = '0; src1_data = '0;
    stall = 1'b0; raddr = '0;

    // Reset state
    look("rst0");
    chk("rst0.we", 64'(we), 64'(0));
    chk("rst0.empty", 64'(empty), 64'(1));
    chk("rst0.rdy1", 64'(src1_ready), 64'(1));
    tick();
    rst_n = 1'b1;

    // Single write, latency one
    src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 32'hDEADBEEF;
    look("sw0");
    chk("sw0.rdy0", 64'(src0_ready), 64'(1));
    tick();
    src0_valid = 1'b0;
    look("sw1");
    chk("sw1.we", 64'(we), 64'(1));
    chk("sw1.waddr", 64'(waddr), 64'(5));
    chk("sw1.wdata", 64'(wdata), 64'hDEADBEEF);
    tick();
    look("sw2");
    chk("sw2.empty", 64'(empty), 64'(1));
    tick();

    // Priority: src1 wins, src0 follows
    src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 32'h11;
    src1_valid = 1'b1; src1_addr = 5'd4; src1_data = 32'h22;
    look("pr0");
    chk("pr0.rdy1", 64'(src1_ready), 64'(1));
    chk("pr0.rdy0", 64'(src0_ready), 64'(0));
    tick();
    src1_valid = 1'b0;
    look("pr1");
    chk("pr1.waddr", 64'(waddr), 64'(4));
    tick();
    src0_valid = 1'b0;
    look("pr2");
    chk("pr2.waddr", 64'(waddr), 64'(3));
    tick();

    // Fill under stall, then drain in order
    stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      src0_valid = 1'b1; src0_addr = AW'(k); src0_data = WW'(32'h100 + k);
      look("fill");
      tick();
    end
    src0_addr = 5'd9;
    look("full");
    chk("full.full", 64'(full), 64'(1));
    chk("full.rdy0", 64'(src0_ready), 64'(0));
    tick();
    src0_valid = 1'b0; stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      look("drain");
      chk("drain.we", 64'(we), 64'(1));
      chk("drain.waddr", 64'(waddr), 64'(k));
      if (k == 2) chk("drain.full", 64'(full), 64'(0));
      tick();
    end
    look("drained");
    chk("drained.empty", 64'(empty), 64'(1));
    tick();

    // Youngest match forwarded
    stall = 1'b1;
    src0_valid = 1'b1; src0_addr = 5'd7; src0_data = 32'hA;
    look("fw0"); tick();
    src0_data = 32'hB;
    look("fw1"); tick();
    src0_valid = 1'b0;
    raddr = {5'd8, 5'd7};
    look("fw2");
    chk("fw2.hit", 64'(fwd_hit), 64'(2'b01));
    chk("fw2.data0", 64'(fwd_data[WW-1:0]), 64'hB);
    tick();
    stall = 1'b0;
    look("fw3");
    chk("fw3.hit", 64'(fwd_hit), 64'(2'b01));
    tick();
    look("fw4"); tick();
    raddr = '0;

    // x0 writes are accepted but dropped
    src1_valid = 1'b1; src1_addr = '0; src1_data = 32'hFF;
    look("x0a");
    chk("x0a.rdy1", 64'(src1_ready), 64'(1));
    tick();
    src1_valid = 1'b0;
    look("x0b");
    chk("x0b.empty", 64'(empty), 64'(1));
    chk("x0b.we", 64'(we), 64'(0));
    chk("x0b.hit", 64'(fwd_hit), 64'(0));
    tick();

    // Reset discards buffered entries
    stall = 1'b1;
    for (int k = 10; k <= 12; k++) begin
      src0_valid = 1'b1; src0_addr = AW'(k); src0_data = WW'(k);
      look("pre_rst");
      tick();
    end
    src0_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_all("mrst");
    chk("mrst.we", 64'(we), 64'(0));
    chk("mrst.empty", 64'(empty), 64'(1));
    look("mrst1");
    tick();
    rst_n = 1'b1; stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      look("post_rst");
      chk("post_rst.we", 64'(we), 64'(0));
      tick();
    end

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      src0_valid = 1'($urandom % 2);
      src0_addr  = AW'($urandom_range(0, 7));
      src0_data  = $urandom;
      src1_valid = 1'(($urandom % 3) == 0);
      src1_addr  = AW'($urandom_range(0, 7));
      src1_data  = $urandom;
      stall      = 1'(($urandom % 3) == 0);
      raddr      = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      if (($urandom % 150) == 0) begin
        rst_n = 1'b0;
        q.delete();
        #1;
        check_all("rnd_rst");
        look("rnd_rst1");
        tick();
        rst_n = 1'b1;
      end else begin
        look("rnd");
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40x_rf_writeback_buffer.md
Name: cv32e40x_rf_writeback_buffer

Overview:
- Write-side initiator for the integer register file. Accepts register writeback requests from two producers: src0 is the ALU/EX result and src1 is the late LSU result.
- Queues accepted requests in a small in-order FIFO and drains one entry per cycle onto a register-file write port (we/waddr/wdata).
- Provides per-read-port forwarding of buffered, not-yet-written data, so operand reads see the newest value.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, 2..8).
- WORD_WIDTH, 32, data width per register word.
- NUM_READ_PORTS, 2, number of forwarding lookup ports.
- ADDR_WIDTH, 5, register address width (4 for RV32E; upper address bits are ignored).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- src0_valid_i  in  1  ALU writeback request.
- src0_ready_o  out  1  ALU request accepted this cycle.
- src0_addr_i  in  ADDR_WIDTH  destination register.
- src0_data_i  in  WORD_WIDTH  result.
- src1_valid_i  in  1  LSU writeback request.
- src1_ready_o  out  1  LSU request accepted this cycle.
- src1_addr_i  in  ADDR_WIDTH  destination register.
- src1_data_i  in  WORD_WIDTH  load data.
- stall_i  in  1  register-file port unavailable; hold the head entry.
- we_o  out  1  register-file write enable.
- waddr_o  out  ADDR_WIDTH  register-file write address.
- wdata_o  out  WORD_WIDTH  register-file write data.
- raddr_i  in  NUM_READ_PORTS x ADDR_WIDTH  lookup addresses.
- fwd_hit_o  out  NUM_READ_PORTS x 1  a buffered entry targets raddr_i[p].
- fwd_data_o  out  NUM_READ_PORTS x WORD_WIDTH  data of the newest matching entry, '0 when no hit.
- empty_o  out  1  buffer empty.
- full_o  out  1  buffer full.

Behaviour:
- Storage: circular FIFO with rd_ptr, wr_ptr and count (0..DEPTH). Each entry holds {addr, data}. Pointers wrap modulo DEPTH.
- Reset (async assert): count=0, pointers=0, entries cleared to '0.
  - Output values in reset: we_o=0, waddr_o=0, wdata_o=0, empty_o=1, full_o=0, fwd_hit_o=0, fwd_data_o='0.
  - Ready outputs remain combinational (see Arbitration), so src1_ready_o=1 in reset.
- Arbitration (combinational):
  - src1 has priority.
  - src1_ready_o = !full_o.
  - src0_ready_o = !full_o && !src1_valid_i.
  - At most one enqueue per cycle; the handshake completes on valid && ready at the posedge.
- x0 filter: a handshake with addr==0 completes (ready as above) but nothing is enqueued and count does not change.
- Enqueue: at the posedge, the entry is written at wr_ptr and wr_ptr increments.
  - There is no same-cycle bypass. An accepted request appears on we_o no earlier than the next cycle (latency 1 when the buffer was empty and stall_i is low).
- Drain (combinational outputs from the head entry):
  - we_o = !empty_o && !stall_i; waddr_o/wdata_o = head entry when !empty_o, else 0.
  - On we_o at the posedge, rd_ptr increments.
  - stall_i holds the head entry; outputs stay stable.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
  - When full, ready is low even if a drain occurs that cycle; this is intentional and keeps ready independent of stall_i.
- Order: entries drain strictly in acceptance order. Two writes to the same register land in order, so the last one wins in the register file.
- Forwarding (combinational, per port p):
  - Compare raddr_i[p] against every valid entry (entries between rd_ptr and wr_ptr).
  - fwd_hit_o[p]=1 if any entry matches and raddr_i[p]!=0.
  - fwd_data_o[p] = data of the youngest matching entry, i.e. closest to wr_ptr going backward.
  - The head entry being written this cycle still counts as a hit, because the register file is updated only at the posedge.
- Width rules: address comparisons use all ADDR_WIDTH bits. Data is passed unmodified.
- Reset mid-operation: all buffered entries are discarded immediately. No write is issued after reset assert.
- Assertions for the bench:
  - count never exceeds DEPTH.
  - we_o never asserts with waddr_o==0.
  - waddr_o/wdata_o are stable while we_o=0 and stall_i=1 with a non-empty buffer.

Test Plan:
- Single write: src0 {x5, 0xDEADBEEF} accepted at cycle 0 -> cycle 1: we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; cycle 2: empty_o=1.
- Priority: src0 {x3, 0x11} and src1 {x4, 0x22} both valid -> src1_ready_o=1, src0_ready_o=0; x4 is written first, then x3 the cycle after src0 is accepted.
- Fill and stall: stall_i=1 and 4 writes x1..x4 -> full_o=1, src0_ready_o=0; release stall -> 4 consecutive we_o pulses, addresses 1,2,3,4 in order, full_o drops after the first drain.
- Forward youngest: buffer holds x7=0xA then x7=0xB with stall_i=1 and raddr_i[0]=7, raddr_i[1]=8 -> fwd_hit_o={0,1}, fwd_data_o[0]=0xB.
- x0 drop: src1 {x0, 0xFF} -> ready=1, count unchanged, no we_o; raddr_i=0 -> fwd_hit_o=0.
- Reset mid-operation: 3 entries buffered, rst_n low for 1 cycle -> we_o=0, empty_o=1, and none of the buffered writes ever appear after reset.
